ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
- Shares one combinational ALU (core plus In1/In2 operand muxes) between two requesters, e.g. the integer pipeline and the address/branch unit.
- Per request: accepts raw MIPS fields (opcode, funct, rs, rt, imm, shamt) and decodes them to the ALU op code and mux selects.
- Drives the external ALU for one cycle, registers the result and zero flag, and returns them on a valid/ready response channel.
- One request in flight at a time; round-robin arbitration.

Parameters:
- DATA_W, 32, operand/result width (only 32 is supported).
- RR_INIT, 0, requester holding priority after reset.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; bit i high only when requester i is granted this cycle.
- req_opcode  in  2x6  instruction opcode per requester.
- req_funct  in  2x6  funct field per requester.
- req_rs  in  2x32  $rs value per requester.
- req_rt  in  2x32  $rt value per requester.
- req_imm  in  2x16  immediate per requester.
- req_shamt  in  2x5  shift amount per requester.
- alu_op  out  5  to ALU core OP.
- alu_in1_sel  out  2  to In1 mux: 00 rt, 01 sign-extended imm, 10 zero-extended imm.
- alu_in2_sel  out  1  to In2 mux: 0 rs, 1 shamt.
- alu_rt  out  32  latched rt operand.
- alu_rs  out  32  latched rs operand.
- alu_imm  out  16  latched imm.
- alu_ext_imm  out  32  sign extension of latched imm.
- alu_shamt  out  5  latched shamt.
- alu_result  in  32  ALU core result.
- alu_zero  in  1  ALU core zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  32  registered result.
- rsp_zero  out  1  registered zero flag.
- rsp_err  out  1  unsupported opcode/funct.

Behaviour:
FSM states and transitions:
- IDLE: if any req_valid bit is set, assert req_ready for the winner only. On the handshake, latch operands, decoded op/selects, err and id, then go to EXEC.
- EXEC: drive ALU outputs from the latched registers. At the clock edge, capture alu_result and alu_zero into the rsp registers, then go to RESP. If err is set, force rsp_result=0 and rsp_zero=1.
- RESP: hold rsp_valid=1 and all rsp_* stable until rsp_ready. On the handshake, go to IDLE.

Timing:
- Latency: request accepted at edge t gives rsp_valid at t+2; throughput is one request per 3 cycles when rsp_ready is held high.
- req_ready is 0 in EXEC and RESP. It is combinational from req_valid and state; there is no combinational path from rsp_ready to req_ready.

Arbitration:
- Round-robin with a 1-bit pointer prio. If only one bit of req_valid is set, that requester wins. If both are set, requester prio wins.
- prio <= ~id on every accept.

Decode, R-type (opcode 0x00), by funct:
- 0x00 sll: op 0, in2 shamt.
- 0x02 srl: op 1, in2 shamt.
- 0x03 sra: op 2, in2 shamt.
- 0x04 sllv: op 3.
- 0x06 srlv: op 4.
- 0x07 srav: op 5.
- 0x20/0x21 add/addu: op 6.
- 0x22/0x23 sub/subu: op 7.
- 0x24 and: op 8.
- 0x25 or: op 9.
- 0x26 xor: op 10.
- 0x27 nor: op 11.
- 0x2A slt: op 12.
- 0x2B sltu: op 13.
- All of the above use in1 = rt. Except where noted, in2 = rs.

Decode, I-type (all use in2 = rs):
- 0x08/0x09 addi/addiu: op 6, in1 sign-extended imm.
- 0x0A slti: op 12, in1 sign-extended imm.
- 0x0B sltiu: op 13, in1 sign-extended imm.
- 0x0C andi: op 8, in1 zero-extended imm.
- 0x0D ori: op 9, in1 zero-extended imm.
- 0x0E xori: op 10, in1 zero-extended imm.
- 0x0F lui: op 14, in1 zero-extended imm.
- Anything else: err=1, op 31, in1 sel 00, in2 sel 0.

Reset values (also applied on reset asserted in any state, including mid-EXEC/RESP, where the in-flight request is dropped):
- state IDLE, prio=RR_INIT.
- req_ready=0 during reset, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
- Latched operands, alu_op and selects all 0.

Decomposition:
- Shared package: state encoding (IDLE, EXEC, RESP), ALU op constants (0-14), in1/in2 select constants, and opcode/funct constants.
- One natural sub-module: ula_decode, combinational opcode/funct to {op, in1_sel, in2_sel, err}.

Test Plan:
- Req0 add, rs=5, rt=3 -> rsp at t+2: result 0x00000008, zero=0, id=0, err=0.
- Req1 sub, rs=7, rt=7 -> result 0, zero=1, id=1.
- Req0 sra, rt=0x80000000, shamt=4 -> result 0xF8000000. Req0 lui, imm=0x1234 -> result 0x12340000.
- Both req_valid high after reset (RR_INIT=0) -> requester 0 served first, then 1, then 0 again while both remain high.
- rsp_ready low for 3 cycles -> rsp_valid and rsp_result stable, req_ready stays 0; request accepted the cycle after the rsp handshake.
- Opcode 0x00 with funct 0x3F -> err=1, result 0, zero=1. Reset asserted in RESP -> next cycle rsp_valid=0, state IDLE.

Source files
------------

// File: rtl/ula_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ula_arbiter_pkg
//   Shared definitions for the shared-ALU arbiter:
//     - FSM state encoding (IDLE / EXEC / RESP)
//     - ALU core op codes driven on alu_op
//     - In1 / In2 operand mux select codes
//     - MIPS opcode and funct field values recognised by the decoder
// ----------------------------------------------------------------------------
package ula_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALU core operations
    localparam logic [4:0] OP_SLL     = 5'd0;
    localparam logic [4:0] OP_SRL     = 5'd1;
    localparam logic [4:0] OP_SRA     = 5'd2;
    localparam logic [4:0] OP_SLLV    = 5'd3;
    localparam logic [4:0] OP_SRLV    = 5'd4;
    localparam logic [4:0] OP_SRAV    = 5'd5;
    localparam logic [4:0] OP_ADD     = 5'd6;
    localparam logic [4:0] OP_SUB     = 5'd7;
    localparam logic [4:0] OP_AND     = 5'd8;
    localparam logic [4:0] OP_OR      = 5'd9;
    localparam logic [4:0] OP_XOR     = 5'd10;
    localparam logic [4:0] OP_NOR     = 5'd11;
    localparam logic [4:0] OP_SLT     = 5'd12;
    localparam logic [4:0] OP_SLTU    = 5'd13;
    localparam logic [4:0] OP_LUI     = 5'd14;
    localparam logic [4:0] OP_INVALID = 5'd31;

    // In1 mux selects
    localparam logic [1:0] IN1_RT       = 2'b00;
    localparam logic [1:0] IN1_SEXT_IMM = 2'b01;
    localparam logic [1:0] IN1_ZEXT_IMM = 2'b10;

    // In2 mux selects
    localparam logic IN2_RS    = 1'b0;
    localparam logic IN2_SHAMT = 1'b1;

    // Opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    // R-type funct values
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/ula_decode.sv
// ----------------------------------------------------------------------------
// ula_decode
//   Combinational MIPS opcode/funct decoder for the shared ALU.
//   Ports:
//     opcode  in  6  instruction opcode
//     funct   in  6  R-type funct field
//     op      out 5  ALU core op code (31 when unsupported)
//     in1_sel out 2  In1 mux select (rt / sign-ext imm / zero-ext imm)
//     in2_sel out 1  In2 mux select (rs / shamt)
//     err     out 1  opcode/funct combination not supported
// ----------------------------------------------------------------------------
module ula_decode
    import ula_arbiter_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [4:0] op,
    output logic [1:0] in1_sel,
    output logic       in2_sel,
    output logic       err
);

    always_comb begin
        // Anything not matched below is reported as unsupported.
        op      = OP_INVALID;
        in1_sel = IN1_RT;
        in2_sel = IN2_RS;
        err     = 1'b1;

        if (opcode == OPC_RTYPE) begin
            err = 1'b0;
            case (funct)
                FN_SLL:          begin op = OP_SLL; in2_sel = IN2_SHAMT; end
                FN_SRL:          begin op = OP_SRL; in2_sel = IN2_SHAMT; end
                FN_SRA:          begin op = OP_SRA; in2_sel = IN2_SHAMT; end
                FN_SLLV:         op = OP_SLLV;
                FN_SRLV:         op = OP_SRLV;
                FN_SRAV:         op = OP_SRAV;
                FN_ADD, FN_ADDU: op = OP_ADD;
                FN_SUB, FN_SUBU: op = OP_SUB;
                FN_AND:          op = OP_AND;
                FN_OR:           op = OP_OR;
                FN_XOR:          op = OP_XOR;
                FN_NOR:          op = OP_NOR;
                FN_SLT:          op = OP_SLT;
                FN_SLTU:         op = OP_SLTU;
                default: begin
                    op  = OP_INVALID;
                    err = 1'b1;
                end
            endcase
        end else begin
            case (opcode)
                OPC_ADDI, OPC_ADDIU: begin op = OP_ADD;  in1_sel = IN1_SEXT_IMM; err = 1'b0; end
                OPC_SLTI:            begin op = OP_SLT;  in1_sel = IN1_SEXT_IMM; err = 1'b0; end
                OPC_SLTIU:           begin op = OP_SLTU; in1_sel = IN1_SEXT_IMM; err = 1'b0; end
                OPC_ANDI:            begin op = OP_AND;  in1_sel = IN1_ZEXT_IMM; err = 1'b0; end
                OPC_ORI:             begin op = OP_OR;   in1_sel = IN1_ZEXT_IMM; err = 1'b0; end
                OPC_XORI:            begin op = OP_XOR;  in1_sel = IN1_ZEXT_IMM; err = 1'b0; end
                OPC_LUI:             begin op = OP_LUI;  in1_sel = IN1_ZEXT_IMM; err = 1'b0; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// ----------------------------------------------------------------------------
// ula_arbiter
//   Shares one external combinational ALU between two requesters. A granted
//   request is decoded and latched, drives the ALU for one cycle (EXEC), and
//   the captured result is returned on a valid/ready response channel (RESP).
//   One request in flight; round-robin arbitration between the requesters.
//
//   Ports:
//     clock, reset            clock and synchronous active-high reset
//     req_valid/req_ready     per-requester handshake (bit i = requester i)
//     req_opcode/funct/rs/rt/imm/shamt
//                             flattened per-requester fields, requester i in
//                             slice [i*W +: W]
//     alu_op, alu_in1_sel, alu_in2_sel, alu_rt, alu_rs, alu_imm,
//     alu_ext_imm, alu_shamt  latched drive to the ALU core and its muxes
//     alu_result, alu_zero    ALU core outputs
//     rsp_valid/rsp_ready     response handshake
//     rsp_id, rsp_result, rsp_zero, rsp_err
//                             registered response payload
// ----------------------------------------------------------------------------
module ula_arbiter
    import ula_arbiter_pkg::*;
#(
    parameter int   DATA_W  = 32,
    parameter logic RR_INIT = 1'b0
) (
    input  logic                clock,
    input  logic                reset,

    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [11:0]         req_opcode,
    input  logic [11:0]         req_funct,
    input  logic [2*DATA_W-1:0] req_rs,
    input  logic [2*DATA_W-1:0] req_rt,
    input  logic [31:0]         req_imm,
    input  logic [9:0]          req_shamt,

    output logic [4:0]          alu_op,
    output logic [1:0]          alu_in1_sel,
    output logic                alu_in2_sel,
    output logic [DATA_W-1:0]   alu_rt,
    output logic [DATA_W-1:0]   alu_rs,
    output logic [15:0]         alu_imm,
    output logic [DATA_W-1:0]   alu_ext_imm,
    output logic [4:0]          alu_shamt,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_zero,
    output logic                rsp_err
);

    // ------------------------------------------------------------------
    // Unpack per-requester fields
    // ------------------------------------------------------------------
    logic [5:0]        opcode_arr [2];
    logic [5:0]        funct_arr  [2];
    logic [DATA_W-1:0] rs_arr     [2];
    logic [DATA_W-1:0] rt_arr     [2];
    logic [15:0]       imm_arr    [2];
    logic [4:0]        shamt_arr  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign opcode_arr[gi] = req_opcode[gi*6 +: 6];
            assign funct_arr[gi]  = req_funct[gi*6 +: 6];
            assign rs_arr[gi]     = req_rs[gi*DATA_W +: DATA_W];
            assign rt_arr[gi]     = req_rt[gi*DATA_W +: DATA_W];
            assign imm_arr[gi]    = req_imm[gi*16 +: 16];
            assign shamt_arr[gi]  = req_shamt[gi*5 +: 5];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_reg;
    logic              prio_reg;
    logic [4:0]        op_reg;
    logic [1:0]        in1_sel_reg;
    logic              in2_sel_reg;
    logic              err_reg;
    logic              id_reg;
    logic [DATA_W-1:0] rs_reg;
    logic [DATA_W-1:0] rt_reg;
    logic [15:0]       imm_reg;
    logic [4:0]        shamt_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_result_reg;
    logic              rsp_zero_reg;
    logic              rsp_err_reg;
    logic              rsp_id_reg;

    // ------------------------------------------------------------------
    // Round-robin winner: a lone requester always wins, a tie goes to prio.
    // ------------------------------------------------------------------
    logic win_id_next;
    logic any_valid;

    always_comb begin
        any_valid = |req_valid;
        if (&req_valid)
            win_id_next = prio_reg;
        else
            win_id_next = req_valid[1];
    end

    // Depends only on state, reset and req_valid; rsp_ready never reaches it.
    always_comb begin
        req_ready = 2'b00;
        if (!reset && state_reg == ST_IDLE && any_valid)
            req_ready[win_id_next] = 1'b1;
    end

    // Single decoder placed after the winner mux.
    logic [4:0] dec_op;
    logic [1:0] dec_in1_sel;
    logic       dec_in2_sel;
    logic       dec_err;

    ula_decode u_decode (
        .opcode  (opcode_arr[win_id_next]),
        .funct   (funct_arr[win_id_next]),
        .op      (dec_op),
        .in1_sel (dec_in1_sel),
        .in2_sel (dec_in2_sel),
        .err     (dec_err)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            prio_reg       <= RR_INIT;
            op_reg         <= '0;
            in1_sel_reg    <= '0;
            in2_sel_reg    <= 1'b0;
            err_reg        <= 1'b0;
            id_reg         <= 1'b0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            imm_reg        <= '0;
            shamt_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_id_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_valid) begin
                        op_reg      <= dec_op;
                        in1_sel_reg <= dec_in1_sel;
                        in2_sel_reg <= dec_in2_sel;
                        err_reg     <= dec_err;
                        id_reg      <= win_id_next;
                        rs_reg      <= rs_arr[win_id_next];
                        rt_reg      <= rt_arr[win_id_next];
                        imm_reg     <= imm_arr[win_id_next];
                        shamt_reg   <= shamt_arr[win_id_next];
                        prio_reg    <= ~win_id_next;
                        state_reg   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Unsupported instructions report a clean zero result.
                    rsp_result_reg <= err_reg ? '0 : alu_result;
                    rsp_zero_reg   <= err_reg ? 1'b1 : alu_zero;
                    rsp_err_reg    <= err_reg;
                    rsp_id_reg     <= id_reg;
                    rsp_valid_reg  <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_op      = op_reg;
    assign alu_in1_sel = in1_sel_reg;
    assign alu_in2_sel = in2_sel_reg;
    assign alu_rt      = rt_reg;
    assign alu_rs      = rs_reg;
    assign alu_imm     = imm_reg;
    assign alu_ext_imm = {{(DATA_W-16){imm_reg[15]}}, imm_reg};
    assign alu_shamt   = shamt_reg;

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_result  = rsp_result_reg;
    assign rsp_zero    = rsp_zero_reg;
    assign rsp_err     = rsp_err_reg;

endmodule

// File: tb/tb_ula_arbiter.sv
module tb_ula_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [11:0] req_opcode;
    logic [11:0] req_funct;
    logic [63:0] req_rs;
    logic [63:0] req_rt;
    logic [31:0] req_imm;
    logic [9:0]  req_shamt;
    logic [4:0]  alu_op;
    logic [1:0]  alu_in1_sel;
    logic        alu_in2_sel;
    logic [31:0] alu_rt;
    logic [31:0] alu_rs;
    logic [15:0] alu_imm;
    logic [31:0] alu_ext_imm;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ula_arbiter #(.DATA_W(32), .RR_INIT(1'b0)) dut (
        .clock       (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_funct   (req_funct),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_imm     (req_imm),
        .req_shamt   (req_shamt),
        .alu_op      (alu_op),
        .alu_in1_sel (alu_in1_sel),
        .alu_in2_sel (alu_in2_sel),
        .alu_rt      (alu_rt),
        .alu_rs      (alu_rs),
        .alu_imm     (alu_imm),
        .alu_ext_imm (alu_ext_imm),
        .alu_shamt   (alu_shamt),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err)
    );

    // External ALU core with its operand muxes: result = f(In1, In2),
    // In1 = rt / imm, In2 = rs / shamt (so sub is rs - rt, slt is rs < rt).
    logic [31:0] in1;
    logic [31:0] in2;
    always_comb begin
        case (alu_in1_sel)
            2'b00:   in1 = alu_rt;
            2'b01:   in1 = alu_ext_imm;
            2'b10:   in1 = {16'h0000, alu_imm};
            default: in1 = 32'h0;
        endcase
        in2 = alu_in2_sel ? {27'h0, alu_shamt} : alu_rs;
        case (alu_op)
            5'd0, 5'd3: alu_result = in1 << in2[4:0];
            5'd1, 5'd4: alu_result = in1 >> in2[4:0];
            5'd2, 5'd5: alu_result = $unsigned($signed(in1) >>> in2[4:0]);
            5'd6:       alu_result = in1 + in2;
            5'd7:       alu_result = in2 - in1;
            5'd8:       alu_result = in1 & in2;
            5'd9:       alu_result = in1 | in2;
            5'd10:      alu_result = in1 ^ in2;
            5'd11:      alu_result = ~(in1 | in2);
            5'd12:      alu_result = {31'h0, $signed(in2) < $signed(in1)};
            5'd13:      alu_result = {31'h0, in2 < in1};
            5'd14:      alu_result = in1 << 16;
            default:    alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int id, input logic [5:0] opc, input logic [5:0] fn,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [15:0] imm, input logic [4:0] sh);
        req_opcode[id*6 +: 6]  = opc;
        req_funct[id*6 +: 6]   = fn;
        req_rs[id*32 +: 32]    = rs;
        req_rt[id*32 +: 32]    = rt;
        req_imm[id*16 +: 16]   = imm;
        req_shamt[id*5 +: 5]   = sh;
        req_valid[id]          = 1'b1;
    endtask

    // Bounded wait until requester id is granted; returns just after the
    // accepting edge.
    task automatic wait_accept(input int id, input string tag);
        #1;
        for (int c = 0; c < 20; c++) begin
            if (req_ready[id]) break;
            @(negedge clk); #1;
        end
        check({tag, "_accept"}, 32'(req_ready[id]), 32'd1);
        @(posedge clk); #1;
    endtask

    // Full transaction with rsp_ready held high.
    task automatic do_txn(input string tag, input int id, input logic [5:0] opc,
                          input logic [5:0] fn, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [15:0] imm,
                          input logic [4:0] sh, input logic [4:0] exp_op,
                          input logic [31:0] exp_res, input logic exp_zero,
                          input logic exp_err);
        @(negedge clk);
        drive_req(id, opc, fn, rs, rt, imm, sh);
        wait_accept(id, tag);
        req_valid[id] = 1'b0;
        @(negedge clk);
        check({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_alu_op"}, 32'(alu_op), 32'(exp_op));
        check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_rsp_result"}, rsp_result, exp_res);
        check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        $display("txn %s: id=%0d op=%0d result=%h zero=%0d err=%0d",
                 tag, id, alu_op, rsp_result, rsp_zero, rsp_err);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] exp_grant [3];
    logic [31:0] exp_sum  [3];

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_opcode = '0;
        req_funct  = '0;
        req_rs     = '0;
        req_rt     = '0;
        req_imm    = '0;
        req_shamt  = '0;
        rsp_ready  = 1'b1;

        // Reset state, with a request pending to show req_ready stays low.
        repeat (2) @(negedge clk);
        req_valid = 2'b01;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_alu_op", 32'(alu_op), 32'd0);
        check("reset_alu_rt", alu_rt, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;

        // Directed instruction vectors
        do_txn("add",   0, 6'h00, 6'h20, 32'd5, 32'd3, 16'h0, 5'd0, 5'd6, 32'h00000008, 1'b0, 1'b0);
        do_txn("sub",   1, 6'h00, 6'h22, 32'd7, 32'd7, 16'h0, 5'd0, 5'd7, 32'h00000000, 1'b1, 1'b0);
        do_txn("sra",   0, 6'h00, 6'h03, 32'd0, 32'h80000000, 16'h0, 5'd4, 5'd2, 32'hF8000000, 1'b0, 1'b0);
        do_txn("lui",   0, 6'h0F, 6'h00, 32'd0, 32'd0, 16'h1234, 5'd0, 5'd14, 32'h12340000, 1'b0, 1'b0);
        do_txn("ori",   1, 6'h0D, 6'h00, 32'h00FF0000, 32'd0, 16'h8001, 5'd0, 5'd9, 32'h00FF8001, 1'b0, 1'b0);
        do_txn("addi",  1, 6'h08, 6'h00, 32'd10, 32'd0, 16'hFFFF, 5'd0, 5'd6, 32'h00000009, 1'b0, 1'b0);
        do_txn("slt",   0, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 16'h0, 5'd0, 5'd12, 32'h00000001, 1'b0, 1'b0);
        do_txn("badfn", 0, 6'h00, 6'h3F, 32'd5, 32'd3, 16'h0, 5'd0, 5'd31, 32'h00000000, 1'b1, 1'b1);
        do_txn("badop", 1, 6'h23, 6'h20, 32'd5, 32'd3, 16'h0, 5'd0, 5'd31, 32'h00000000, 1'b1, 1'b1);

        // Round-robin with both requesters held valid after reset
        apply_reset();
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
        exp_sum[0]   = 32'd2; exp_sum[1]   = 32'd30; exp_sum[2]  = 32'd2;
        @(negedge clk);
        drive_req(0, 6'h00, 6'h20, 32'd1, 32'd1, 16'h0, 5'd0);
        drive_req(1, 6'h00, 6'h20, 32'd10, 32'd20, 16'h0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            for (int c = 0; c < 20; c++) begin
                if (req_ready != 2'b00) break;
                @(negedge clk); #1;
            end
            check("rr_grant", 32'(req_ready), 32'(exp_grant[k]));
            @(posedge clk);
            @(negedge clk);
            @(negedge clk);
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_id", 32'(rsp_id), 32'(exp_grant[k][1]));
            check("rr_rsp_result", rsp_result, exp_sum[k]);
            $display("rr %0d: id=%0d result=%h", k, rsp_id, rsp_result);
            if (k == 2) req_valid = 2'b00;
            @(negedge clk);
        end

        // Response backpressure
        rsp_ready = 1'b0;
        drive_req(0, 6'h00, 6'h20, 32'd100, 32'd1, 16'h0, 5'd0);
        wait_accept(0, "bp");
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        drive_req(1, 6'h00, 6'h22, 32'd9, 32'd4, 16'h0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_result", rsp_result, 32'd101);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_no_comb_path", 32'(req_ready), 32'd0);
        $display("bp: held result=%h", rsp_result);
        @(negedge clk);
        check("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp2_rsp_id", 32'(rsp_id), 32'd1);
        check("bp2_rsp_result", rsp_result, 32'd5);
        $display("bp2: id=%0d result=%h", rsp_id, rsp_result);
        @(negedge clk);

        // Reset while a response is pending
        rsp_ready = 1'b0;
        drive_req(0, 6'h00, 6'h20, 32'd5, 32'd3, 16'h0, 5'd0);
        wait_accept(0, "rst");
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_valid", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_rs", alu_rs, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("rst_idle_grant", 32'(req_ready), 32'b10);
        $display("rst: rsp_valid=%0d req_ready=%b", rsp_valid, req_ready);
        req_valid = 2'b00;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
